// File: rtl/rx_frame_guard.sv
`default_nettype none
// ============================================================================
// rx_frame_guard : store-and-forward Avalon-ST receive buffer that releases
//                  only complete, error-free frames and drops everything else.
//                  Define RX_FRAME_GUARD_STATS_EN to build frame/drop counters.
// Revision 1.0
// ============================================================================

module rx_frame_guard #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_empty,
    input  logic [5:0]  in_error,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  out_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int                c_pw       = DEPTH_LOG2 + 1;
    localparam logic [c_pw-1:0]   c_depth    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_pw-1:0]   c_one      = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [1:0]        c_st_idle    = 2'd0;
    localparam logic [1:0]        c_st_write   = 2'd1;
    localparam logic [1:0]        c_st_discard = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      w_frame_dest;
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_commit_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] w_wr_ptr_nxt;
    logic [c_pw-1:0] w_commit_ptr_nxt;
    logic [c_pw-1:0] w_pos;
    logic            w_acc;
    logic            w_start;
    logic            w_frame_beat;
    logic            w_full;
    logic            w_bad;
    logic            w_we;
    logic            w_commit;
    logic            w_load;
    logic [35:0]     r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [35:0]     w_rd_word;
    logic [35:0]     r_out_word;
    logic            r_out_valid;

    assign in_ready     = reset_n;
    assign w_acc        = in_valid & in_ready;
    assign w_start      = w_acc & in_sop;
    assign w_frame_beat = w_start | (w_acc & (r_state == c_st_write));
    // A sop always (re)starts at the last commit point, discarding any partial frame.
    assign w_pos        = w_start ? r_commit_ptr : r_wr_ptr;
    assign w_full       = (w_pos - r_rd_ptr) == c_depth;
    assign w_bad        = w_full | (in_eop ? (in_error != 6'd0) : (in_empty != 2'd0));
    assign w_frame_dest = in_eop ? c_st_idle : (w_bad ? c_st_discard : c_st_write);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_write: begin
                if (w_frame_beat) w_state_nxt = w_frame_dest;
            end
            c_st_discard: begin
                if (w_frame_beat)          w_state_nxt = w_frame_dest;
                else if (w_acc && in_eop)  w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_we             = w_frame_beat & ~w_bad;
        w_commit         = w_we & in_eop;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        if (w_frame_beat) w_wr_ptr_nxt = w_bad ? r_commit_ptr : (w_pos + c_one);
        if (w_commit)     w_commit_ptr_nxt = w_pos + c_one;
    end

    always_ff @(posedge sys_clk) begin
        if (w_we) r_mem[w_pos[DEPTH_LOG2-1:0]] <= {in_data, in_sop, in_eop, in_empty};
    end

    // Output register doubles as a one-word skid: refill whenever it empties or is consumed.
    assign w_rd_word = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign w_load    = (r_rd_ptr != r_commit_ptr) & (~r_out_valid | out_ready);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_rd_ptr    <= r_rd_ptr + c_one;
            r_out_word  <= w_rd_word;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_word[35:4];
    assign out_sop   = r_out_word[3];
    assign out_eop   = r_out_word[2];
    assign out_empty = r_out_word[1:0];
    assign out_valid = r_out_valid;

`ifdef RX_FRAME_GUARD_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;
    logic [1:0]  w_drops;
    logic [16:0] w_drop_sum;

    // A restarting sop can drop the old partial frame and the new beat in one cycle.
    assign w_drops    = {1'b0, w_start & (r_state == c_st_write)} + {1'b0, w_frame_beat & w_bad};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drops};

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_commit && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign frame_count = r_frame_cnt;
    assign drop_count  = r_drop_cnt;
`else
    assign frame_count = 16'd0;
    assign drop_count  = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_guard.sv
`default_nettype none
// ============================================================================
// tb_rx_frame_guard : scoreboard bench for rx_frame_guard with a frame-level
//                     reference model. Revision 1.0
// ============================================================================

module tb_rx_frame_guard;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_empty;
    logic [5:0]  in_error;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    rx_frame_guard #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .in_error   (in_error),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_count(frame_count),
        .drop_count (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    beat_t cur_q[$];
    bit    m_in_frame = 1'b0;
    int    m_frames   = 0;
    int    m_drops    = 0;
    bit    rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is forwarded only if every beat is clean and it fits.
    task automatic model_beat(input beat_t b, input logic [5:0] err);
        bit bad;
        if (b.sop) begin
            if (m_in_frame) m_drops++;
            m_in_frame = 1'b1;
            cur_q.delete();
        end
        if (m_in_frame) begin
            bad = (exp_q.size() + cur_q.size() >= DEPTH) ||
                  (b.eop ? (err != 6'd0) : (b.empty != 2'd0));
            if (bad) begin
                m_drops++;
                m_in_frame = 1'b0;
            end else begin
                cur_q.push_back(b);
                if (b.eop) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    m_frames++;
                    m_in_frame = 1'b0;
                end
            end
        end
    endtask

    task automatic send_beat(input beat_t b, input logic [5:0] err);
        in_data  = b.data;
        in_sop   = b.sop;
        in_eop   = b.eop;
        in_empty = b.empty;
        in_error = err;
        in_valid = 1'b1;
        model_beat(b, err);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input int len, input logic [5:0] err, input bit with_eop,
                              input logic [1:0] eop_empty);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = $urandom;
            b.sop   = (i == 0);
            b.eop   = with_eop && (i == len - 1);
            b.empty = b.eop ? eop_empty : 2'd0;
            send_beat(b, b.eop ? err : 6'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        check("drain_remaining", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic check_counts(input string tag);
`ifdef RX_FRAME_GUARD_STATS_EN
        check({tag, "_frame_count"}, frame_count, (m_frames > 65535) ? 65535 : m_frames);
        check({tag, "_drop_count"},  drop_count,  (m_drops  > 65535) ? 65535 : m_drops);
`else
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_drop_count"},  drop_count,  0);
`endif
    endtask

    // Monitor: consume beats at negedge, checking order and stall stability.
    bit          stall_prev = 1'b0;
    logic [36:0] prev_out;
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {out_valid, out_data, out_sop, out_eop, out_empty}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {out_data, out_sop, out_eop, out_empty}, 64'hDEAD_BEEF_DEAD);
                end else begin
                    check("out_beat", {out_data, out_sop, out_eop, out_empty}, exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_data, out_sop, out_eop, out_empty};
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int    t;
        int    len;
        int    kind;
        beat_t b;

        reset_n  = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
        in_error = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_flags", {out_sop, out_eop, out_empty}, 0);
        check("rst_out_data",  out_data,  0);
        check_counts("rst");
        reset_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        @(posedge sys_clk);
        #1;
        idle(2);

        // 16-beat frame: latency and gap-free streaming
        send_frame(16, 6'd0, 1'b1, 2'd0);
        check("latency_n1_valid", out_valid, 0);
        @(posedge sys_clk);
        #1;
        check("latency_n2_valid_sop", {out_valid, out_sop}, 2'b11);
        for (int i = 0; i < 15; i++) begin
            @(posedge sys_clk);
            #1;
            check("no_bubble", out_valid, 1);
        end
        wait_drain();
        check_counts("single");

        // errored frame followed by good frame
        send_frame(3, 6'h01, 1'b1, 2'd0);
        send_frame(4, 6'd0, 1'b1, 2'd1);
        wait_drain();
        check_counts("error_drop");

        // oversize frame overflows the buffer
        out_ready = 1'b0;
        send_frame(20, 6'd0, 1'b1, 2'd0);
        idle(3);
        check("overflow_no_output", out_valid, 0);
        out_ready = 1'b1;
        send_frame(4, 6'd0, 1'b1, 2'd2);
        wait_drain();
        check_counts("overflow");

        // three frames buffered behind a stalled sink
        out_ready = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(4, 6'd0, 1'b1, 2'(f));
        idle(10);
        check("stall_valid_head", {out_valid, out_sop}, 2'b11);
        out_ready = 1'b1;
        wait_drain();
        check_counts("stall");

        // unfinished frame cut by a new sop
        send_frame(3, 6'd0, 1'b0, 2'd0);
        send_frame(5, 6'd0, 1'b1, 2'd3);
        wait_drain();
        check_counts("restart");

        // reset during readout
        send_frame(8, 6'd0, 1'b1, 2'd0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        idle(2);
        reset_n = 1'b0;
        exp_q.delete();
        cur_q.delete();
        m_in_frame = 1'b0;
        m_frames   = 0;
        m_drops    = 0;
        #1;
        check("reset_mid_out_valid", out_valid, 0);
        check("reset_mid_in_ready",  in_ready,  0);
        check("reset_mid_out_data",  {out_data, out_sop, out_eop, out_empty}, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        idle(10);
        check("post_reset_quiet", out_valid, 0);
        check_counts("post_reset");
        send_frame(2, 6'd0, 1'b1, 2'd1);
        wait_drain();
        check_counts("post_reset_frame");

        // randomized traffic with random backpressure
        rand_ready_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            t = 0;
            while (exp_q.size() > 8 && t < 400) begin
                @(posedge sys_clk);
                #1;
                t++;
            end
            if (t >= 400) check("rand_backlog_timeout", exp_q.size(), 0);
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                b.data = $urandom; b.sop = 1'b0; b.eop = 1'b0; b.empty = 2'd0;
                send_beat(b, 6'd0);
            end
            len  = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            for (int i = 0; i < len; i++) begin
                b.data  = $urandom;
                b.sop   = (i == 0);
                b.eop   = (kind != 1) && (i == len - 1);
                b.empty = b.eop ? 2'($urandom_range(0, 3)) : 2'd0;
                if (kind == 2 && len >= 3 && i == 1) b.empty = 2'($urandom_range(1, 3));
                send_beat(b, (b.eop && kind == 0) ? 6'($urandom_range(1, 63)) : 6'd0);
            end
            in_valid = 1'b0;
        end
        rand_ready_en = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check_counts("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
